// File: rtl/kyber_pkg.sv
// kyber_pkg: shared Kyber constants, coefficient types and the arithmetic
// helpers used by the inverse-NTT butterfly pipeline.
//
// Contents:
//   KYBER_Q, KYBER_QINV, BARRETT_V, INVNTT_F  reference constants
//   INVNTT_LATENCY                            in_valid -> out_valid cycles
//                                             (6 with INVNTT_SCALE_EN, else 4)
//   coeff_t / dcoeff_t                        signed 16 / 32-bit coefficients
//   barrett_quot, mont_t, mont_fold           single-step arithmetic helpers
package kyber_pkg;

  localparam int KYBER_Q    = 3329;
  localparam int KYBER_QINV = -3327;
  localparam int BARRETT_V  = 20159;
  localparam int INVNTT_F   = 1441;

`ifdef INVNTT_SCALE_EN
  localparam int INVNTT_LATENCY = 6;
`else
  localparam int INVNTT_LATENCY = 4;
`endif

  typedef logic signed [15:0] coeff_t;
  typedef logic signed [31:0] dcoeff_t;

  localparam coeff_t  KYBER_Q_16    = coeff_t'(KYBER_Q);
  localparam coeff_t  KYBER_QINV_16 = coeff_t'(KYBER_QINV);
  localparam dcoeff_t BARRETT_RND   = 32'sd33554432;  // 2^25

  // Barrett quotient estimate: (v*x + 2^25) >>> 26. Magnitude stays below 11.
  function automatic coeff_t barrett_quot(input coeff_t x);
    return coeff_t'((dcoeff_t'(x) * dcoeff_t'(BARRETT_V) + BARRETT_RND) >>> 26);
  endfunction

  // Montgomery multiplier: low half of the product times q^-1, kept as int16.
  // A 16x16 multiply in a 16-bit context yields exactly the wrapped result.
  function automatic coeff_t mont_t(input dcoeff_t prod);
    return coeff_t'(prod[15:0]) * KYBER_QINV_16;
  endfunction

  // Montgomery fold: (prod - t*q) has a zero low half, so the shift is exact.
  function automatic coeff_t mont_fold(input dcoeff_t prod, input coeff_t t);
    return coeff_t'((prod - dcoeff_t'(t) * dcoeff_t'(KYBER_Q)) >>> 16);
  endfunction

endpackage

// File: rtl/barrett_reduce_pipe.sv
// barrett_reduce_pipe: two-stage signed Barrett reduction with valid
// passthrough. Result matches the Kyber reference barrett_reduce and lies
// in [-1664, 1664] for any int16 input.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset (clears the valid chain only)
//   in_valid   sum is valid this cycle
//   sum        int16 value to reduce
//   out_valid  ar is valid (two cycles after in_valid)
//   ar         reduced value
module barrett_reduce_pipe
  import kyber_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   in_valid,
  input  coeff_t sum,
  output logic   out_valid,
  output coeff_t ar
);

  logic   v_q;
  coeff_t sum_q;
  coeff_t bq_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      v_q       <= in_valid;
      out_valid <= v_q;
    end
  end

  // Data regs free-run; only the valid chain decides what is meaningful.
  always_ff @(posedge clk) begin
    sum_q <= sum;
    bq_q  <= barrett_quot(sum);
    ar    <= sum_q - bq_q * KYBER_Q_16;
  end

endmodule

// File: rtl/invntt_butterfly.sv
// invntt_butterfly: pipelined Gentleman-Sande butterfly for the Kyber
// inverse NTT. Per accepted pair:
//   a_out = barrett_reduce(a + b)
//   b_out = fqmul(zeta, b - a)
// One item per clock, no backpressure, results in input order.
//
// Optional feature macro INVNTT_SCALE_EN: adds the scale port and two
// stages applying fqmul(x, 1441) to both outputs when scale=1 (latency 6).
// Without it latency is 4.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   in_valid   a/b/zeta valid this cycle, always accepted
//   a, b       signed coefficients r[j], r[j+len]
//   zeta       signed twiddle, Montgomery domain
//   scale      (INVNTT_SCALE_EN only) apply final 1/128 scaling
//   out_valid  results valid this cycle
//   a_out      new r[j], in [-1664, 1664]
//   b_out      new r[j+len], in (-q, q)
module invntt_butterfly
  import kyber_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   in_valid,
  input  coeff_t a,
  input  coeff_t b,
  input  coeff_t zeta,
`ifdef INVNTT_SCALE_EN
  input  logic   scale,
`endif
  output logic   out_valid,
  output coeff_t a_out,
  output coeff_t b_out
);

  logic    v_1;
  coeff_t  sum_1;
  coeff_t  diff_1;
  coeff_t  zeta_1;
  dcoeff_t prod_2;
  dcoeff_t prod_3;
  coeff_t  t_3;
  coeff_t  ar_3;
  logic    v_3;

  always_ff @(posedge clk) begin
    if (reset) v_1 <= 1'b0;
    else       v_1 <= in_valid;
  end

  // Stage 1: int16 wrap on sum/diff mirrors the C reference.
  // Stages 2-3 of the Montgomery path run beside the Barrett sub-pipe.
  always_ff @(posedge clk) begin
    sum_1  <= a + b;
    diff_1 <= b - a;
    zeta_1 <= zeta;
    prod_2 <= dcoeff_t'(zeta_1) * dcoeff_t'(diff_1);
    prod_3 <= prod_2;
    t_3    <= mont_t(prod_2);
  end

  barrett_reduce_pipe u_barrett (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (v_1),
    .sum       (sum_1),
    .out_valid (v_3),
    .ar        (ar_3)
  );

`ifdef INVNTT_SCALE_EN
  logic    sc_1, sc_2, sc_3, sc_4, sc_5;
  logic    v_4, v_5;
  coeff_t  a_4, b_4, a_5, b_5;
  dcoeff_t pa_5, pb_5;

  always_ff @(posedge clk) begin
    if (reset) begin
      v_4 <= 1'b0;
      v_5 <= 1'b0;
    end else begin
      v_4 <= v_3;
      v_5 <= v_4;
    end
  end

  always_ff @(posedge clk) begin
    sc_1 <= scale;
    sc_2 <= sc_1;
    sc_3 <= sc_2;
    sc_4 <= sc_3;
    sc_5 <= sc_4;
    a_4  <= ar_3;
    b_4  <= mont_fold(prod_3, t_3);
    a_5  <= a_4;
    b_5  <= b_4;
    pa_5 <= dcoeff_t'(a_4) * dcoeff_t'(INVNTT_F);
    pb_5 <= dcoeff_t'(b_4) * dcoeff_t'(INVNTT_F);
  end

  // Stage 6: Montgomery reduction of the scaled products, or plain delay.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      a_out     <= '0;
      b_out     <= '0;
    end else begin
      out_valid <= v_5;
      if (v_5) begin
        a_out <= sc_5 ? mont_fold(pa_5, mont_t(pa_5)) : a_5;
        b_out <= sc_5 ? mont_fold(pb_5, mont_t(pb_5)) : b_5;
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      a_out     <= '0;
      b_out     <= '0;
    end else begin
      out_valid <= v_3;
      if (v_3) begin
        a_out <= ar_3;
        b_out <= mont_fold(prod_3, t_3);
      end
    end
  end
`endif

endmodule

// File: tb/tb_invntt_butterfly.sv
module tb_invntt_butterfly;

`ifdef INVNTT_SCALE_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 4;
`endif

  logic clk = 1'b0;
  logic reset;
  logic in_valid;
  logic signed [15:0] a, b, zeta;
`ifdef INVNTT_SCALE_EN
  logic scale;
`endif
  logic out_valid;
  logic signed [15:0] a_out, b_out;

  invntt_butterfly dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .zeta      (zeta),
`ifdef INVNTT_SCALE_EN
    .scale     (scale),
`endif
    .out_valid (out_valid),
    .a_out     (a_out),
    .b_out     (b_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    shortint a;
    shortint b;
    shortint z;
    bit      sc;
    shortint ea;
    shortint eb;
  } vec_t;

  typedef struct {
    shortint ea;
    shortint eb;
    int      cyc;
  } exp_t;

  vec_t    tbl[$];
  exp_t    sb[$];
  exp_t    e;
  int      cyc = 0;
  logic    rst_q = 1'b0;
  int      checks = 0;
  int      failures = 0;
  shortint last_a = 0;
  shortint last_b = 0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= reset;
  end

  // Reference model written from the Kyber C routines.
  function automatic shortint m_barrett(input shortint x);
    int t;
    t = (20159 * int'(x) + (1 << 25)) >>> 26;
    return shortint'(int'(x) - t * 3329);
  endfunction

  function automatic shortint m_mont(input int x);
    shortint t;
    t = shortint'(int'(shortint'(x)) * -3327);
    return shortint'((x - int'(t) * 3329) >>> 16);
  endfunction

  function automatic shortint m_fqmul(input shortint x, input shortint y);
    return m_mont(int'(x) * int'(y));
  endfunction

  always @(negedge clk) begin
    if (rst_q) begin
      checks++;
      if (out_valid !== 1'b0 || a_out !== 16'sd0 || b_out !== 16'sd0) begin
        failures++;
        $display("FAIL reset_state: out_valid=%0b a_out=%0d b_out=%0d, required 0/0/0",
                 out_valid, a_out, b_out);
      end
      last_a = 0;
      last_b = 0;
    end else if (out_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output: cyc=%0d a_out=%0d b_out=%0d, required no output",
                 cyc, a_out, b_out);
      end else begin
        e = sb.pop_front();
        if (a_out !== e.ea || b_out !== e.eb || (cyc - e.cyc) != LAT) begin
          failures++;
          $display("FAIL item_result: a_out=%0d b_out=%0d latency=%0d, required %0d %0d %0d",
                   a_out, b_out, cyc - e.cyc, e.ea, e.eb, LAT);
        end
      end
      last_a = a_out;
      last_b = b_out;
    end else begin
      checks++;
      if (out_valid !== 1'b0 || a_out !== last_a || b_out !== last_b) begin
        failures++;
        $display("FAIL idle_hold: out_valid=%0b a_out=%0d b_out=%0d, required 0 %0d %0d",
                 out_valid, a_out, b_out, last_a, last_b);
      end
    end
  end

  task automatic send(input shortint ia, input shortint ib, input shortint iz,
                      input bit isc, input bit use_tbl,
                      input shortint ta, input shortint tb_v);
    exp_t    n;
    shortint xa, xb;
    @(posedge clk); #1;
    in_valid = 1'b1;
    a        = ia;
    b        = ib;
    zeta     = iz;
`ifdef INVNTT_SCALE_EN
    scale    = isc;
`endif
    if (use_tbl) begin
      n.ea = ta;
      n.eb = tb_v;
    end else begin
      xa = m_barrett(shortint'(int'(ia) + int'(ib)));
      xb = m_fqmul(iz, shortint'(int'(ib) - int'(ia)));
      if (isc) begin
        xa = m_fqmul(xa, shortint'(1441));
        xb = m_fqmul(xb, shortint'(1441));
      end
      n.ea = xa;
      n.eb = xb;
    end
    n.cyc = cyc;
    sb.push_back(n);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: pending=%0d, required 0", sb.size());
      sb.delete();
    end
    repeat (3) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    shortint ra, rb, rz;
    bit      rs;

    tbl.push_back('{1, 2, 0, 1'b0, 3, 0});
    tbl.push_back('{1, 2, 2285, 1'b0, 3, 1});
    tbl.push_back('{3000, 3000, 0, 1'b0, -658, 0});
    tbl.push_back('{1664, 0, 0, 1'b0, 1664, 0});
    tbl.push_back('{1665, 0, 0, 1'b0, -1664, 0});
    tbl.push_back('{32767, 1, 1, 1'b0, 522, -1327});
    tbl.push_back('{0, 0, 1234, 1'b0, 0, 0});
`ifdef INVNTT_SCALE_EN
    tbl.push_back('{1, 2, 2285, 1'b1, 1536, 512});
    tbl.push_back('{1, 2, 2285, 1'b0, 3, 1});
`endif

    reset    = 1'b1;
    in_valid = 1'b0;
    a        = 0;
    b        = 0;
    zeta     = 0;
`ifdef INVNTT_SCALE_EN
    scale    = 1'b0;
`endif
    repeat (2) @(posedge clk);

    // in_valid pulsed while reset is held: nothing may come out
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      a        = shortint'(i + 1);
      b        = 7;
      zeta     = 100;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    reset    = 1'b0;
    repeat (LAT + 3) @(posedge clk);

    // table vectors, back to back
    foreach (tbl[i])
      send(tbl[i].a, tbl[i].b, tbl[i].z, tbl[i].sc, 1'b1, tbl[i].ea, tbl[i].eb);
    idle();
    drain();

    // 8 back-to-back items with int16 extremes, 2 bubbles, 1 item
    send(-32768, -32768, -32768, 1'b0, 1'b0, 0, 0);
    send(32767, 32767, 32767, 1'b0, 1'b0, 0, 0);
    send(-32768, 32767, 1, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      ra = shortint'($urandom);
      rb = shortint'($urandom);
      rz = shortint'($urandom_range(0, 6657)) - shortint'(3328);
`ifdef INVNTT_SCALE_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      send(ra, rb, rz, rs, 1'b0, 0, 0);
    end
    idle();
    idle();
    send(-1, 32767, -1044, 1'b0, 1'b0, 0, 0);
    idle();
    drain();

    // reset for one cycle with 3 items in flight: all dropped
    send(100, 200, 17, 1'b0, 1'b0, 0, 0);
    send(-300, 45, 2285, 1'b0, 1'b0, 0, 0);
    send(5, 5, 5, 1'b0, 1'b0, 0, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    reset    = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    send(1, 2, 2285, 1'b0, 1'b0, 0, 0);
    idle();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
